capture_readback_ctrl: RTL and testbench
========================================

Name: capture_readback_ctrl

Overview:
- Sequences DRAM readback of a completed capture page over the read half of the DDR memory interface: issues read requests, tracks outstanding reads, and retrieves returned 128-bit words.
- Unpacks each 128-bit word into four 32-bit sample packets on a valid/ready stream for the downstream host link or consumer.
- Sits between the DDR memory interface read ports and the sample consumer; runs in the soc clock domain.

Parameters:
- ADX_W, 27, DRAM address width.
- DATA_W, 128, DRAM word width.
- SAMPLE_W, 32, sample packet width; DATA_W/SAMPLE_W = 4 packets per word.
- ADX_STEP, 8, address increment per DRAM word, in 16-bit units.
- MAX_OUTSTANDING, 8, maximum reads issued but not yet retrieved; power of two, 2..64.
- CNT_W, 24, width of word_count.

Ports:
- clk  in  1  soc clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin readback.
- abort  in  1  level: stop issuing and drain.
- base_adx  in  ADX_W  first DRAM word address, sampled on start.
- word_count  in  CNT_W  number of DRAM words to read, sampled on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  single-cycle pulse at completion or abort.
- read_req  out  1  read command; accepted in any cycle it is high.
- rd_adx  out  ADX_W  read address, valid with read_req.
- read_allowed  in  1  interface can accept a read this cycle.
- reads_pending  in  1  interface still has reads in flight.
- has_return_data  in  1  returned word available.
- get_return_data  out  1  pop one returned word.
- rd_data_return  in  DATA_W  returned data, valid while has_return_data is high.
- rd_adx_return  in  ADX_W  address of the returned data.
- sample_out  out  SAMPLE_W  unpacked sample packet.
- sample_valid  out  1  sample_out valid.
- sample_ready  in  1  consumer accepts sample_out.
- adx_error  out  1  sticky return-address mismatch flag.

Behaviour:
- Reset: every output is 0. State is IDLE, all counters are 0, and the unpack buffer is empty.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start, latch base_adx into next_adx, latch word_count, and clear issued, outstanding and adx_error.
  - busy goes high in the following cycle.
  - If word_count is 0, go to DONE; otherwise go to ISSUE.
  - start is ignored in every state other than IDLE.
- ISSUE:
  - read_req is combinational and equals (issued < word_count) AND (outstanding < MAX_OUTSTANDING) AND read_allowed AND NOT abort.
  - rd_adx = next_adx.
  - On read_req: next_adx += ADX_STEP, with ADX_W wrap-around modulo 2^ADX_W; issued += 1; outstanding += 1.
  - At most one request is issued per cycle.
  - Go to DRAIN when issued == word_count, or when abort is high.
- Return path, active in every state:
  - get_return_data = has_return_data AND unpack buffer empty AND outstanding != 0.
  - On a pop, the word loads into the buffer at the next edge, outstanding -= 1, and expect_adx += ADX_STEP.
  - An issue and a pop in the same cycle leave outstanding unchanged.
- Unpack buffer:
  - Holds one word with slot index 0..3.
  - sample_out = bits [32*slot+31 : 32*slot]; slot 0 (the LSBs) is emitted first.
  - sample_valid is high while the buffer is full.
  - On sample_valid AND sample_ready, slot advances; after slot 3 the buffer is empty.
  - Pop-to-first-sample_valid latency is 1 cycle.
  - A full word streams in 4 cycles under continuous sample_ready.
- DRAIN:
  - No new requests.
  - Once abort has been seen (latched internally), popped words are discarded: sample_valid stays 0 and the buffer is cleared.
  - Go to DONE when outstanding == 0, the buffer is empty, and reads_pending == 0.
- DONE: done pulses high for 1 cycle, busy drops with it, then return to IDLE.
- abort in IDLE has no effect. The abort latch clears on the next start.
- resetn asserted mid-operation: everything returns immediately to reset values. Late returns arriving after reset are not popped, because outstanding == 0.

Optional Feature:
- Macro: READBACK_ADX_CHECK_EN.
- Defined: each popped rd_adx_return is compared with expect_adx (which starts at base_adx). A mismatch sets adx_error; adx_error stays set until the next accepted start. Data still passes through.
- Not defined: the comparator and expect_adx are removed and adx_error is tied to 0.

Test Plan:
- base_adx=0x100, word_count=2, read_allowed=1, sample_ready=1, returns 2 cycles after issue -> rd_adx 0x100 then 0x108 on consecutive cycles; 8 samples emitted in LSB-first order; one done pulse; busy low afterwards.
- word_count=20, returns withheld -> exactly 8 read_req issued, then stall; releasing returns resumes issuing; 80 samples total, in order, none dropped.
- sample_ready toggled 1/0 randomly -> sample_out held stable while sample_valid=1 and sample_ready=0; sequence identical to the no-backpressure run.
- word_count=10, abort asserted after 4 issues with 3 outstanding -> no further read_req; 3 words popped and discarded; done only after reads_pending=0.
- word_count=0 -> done pulse 2 cycles after start; no read_req. start asserted while busy -> ignored.
- READBACK_ADX_CHECK_EN defined, second return address forced to 0x1FF -> adx_error=1 after that pop; stays 1 through done; cleared by next start.

Source files
------------

// File: rtl/capture_readback_ctrl.sv
// Capture-page DRAM readback sequencer: issues reads, tracks outstanding words, unpacks them into samples.
// Optional return-address checking (adx_error) is enabled by defining READBACK_ADX_CHECK_EN.
module capture_readback_ctrl #(
   parameter int unsigned ADX_W           = 27,
   parameter int unsigned DATA_W          = 128,
   parameter int unsigned SAMPLE_W        = 32,
   parameter int unsigned ADX_STEP        = 8,
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned CNT_W           = 24
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                abort,
   input  logic [ADX_W-1:0]    base_adx,
   input  logic [CNT_W-1:0]    word_count,
   output logic                busy,
   output logic                done,
   output logic                read_req,
   output logic [ADX_W-1:0]    rd_adx,
   input  logic                read_allowed,
   input  logic                reads_pending,
   input  logic                has_return_data,
   output logic                get_return_data,
   input  logic [DATA_W-1:0]   rd_data_return,
   input  logic [ADX_W-1:0]    rd_adx_return,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                adx_error
);

   localparam int unsigned NSLOT  = DATA_W / SAMPLE_W;
   localparam int unsigned SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;

   localparam logic [ADX_W-1:0]  STEP      = ADX_W'(ADX_STEP);
   localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADX_W-1:0]    next_adx_q, next_adx_d;
   logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]    issued_q, issued_d;
   logic [OUT_W-1:0]    outst_q, outst_d;
   logic                abort_seen_q, abort_seen_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic                buf_full_q, buf_full_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;

   logic issue;
   logic pop;
   logic accept;
   logic start_ok;

   assign start_ok = (state_q == IDLE) && start;
   assign issue    = (state_q == ISSUE) && (issued_q < word_cnt_q) && (outst_q < OUT_MAX)
                     && read_allowed && !abort;
   assign pop      = has_return_data && !buf_full_q && (outst_q != '0);
   assign accept   = buf_full_q && !abort_seen_q && sample_ready;

   always_comb begin
      state_d      = state_q;
      next_adx_d   = next_adx_q;
      word_cnt_d   = word_cnt_q;
      issued_d     = issued_q;
      outst_d      = outst_q;
      abort_seen_d = abort_seen_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case ({issue, pop})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               next_adx_d   = base_adx;
               word_cnt_d   = word_count;
               issued_d     = '0;
               outst_d      = '0;
               abort_seen_d = 1'b0;
               busy_d       = 1'b1;
               state_d      = (word_count == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               next_adx_d = next_adx_q + STEP;
               issued_d   = issued_q + CNT_W'(1);
            end
            if (abort) abort_seen_d = 1'b1;
            if (abort || (issued_q == word_cnt_q)) state_d = DRAIN;
         end
         DRAIN: begin
            if (abort) abort_seen_d = 1'b1;
            if ((outst_q == '0) && !buf_full_q && !reads_pending) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Once aborted, any popped word is dropped and the buffer is held empty.
   always_comb begin
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      slot_d     = slot_q;
      if (abort_seen_q) begin
         buf_full_d = 1'b0;
         slot_d     = '0;
      end else if (pop) begin
         buf_d      = rd_data_return;
         buf_full_d = 1'b1;
         slot_d     = '0;
      end else if (accept) begin
         if (slot_q == SLOT_LAST) begin
            buf_full_d = 1'b0;
            slot_d     = '0;
         end else begin
            slot_d = slot_q + SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         next_adx_q   <= '0;
         word_cnt_q   <= '0;
         issued_q     <= '0;
         outst_q      <= '0;
         abort_seen_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         buf_q        <= '0;
         buf_full_q   <= 1'b0;
         slot_q       <= '0;
      end else begin
         state_q      <= state_d;
         next_adx_q   <= next_adx_d;
         word_cnt_q   <= word_cnt_d;
         issued_q     <= issued_d;
         outst_q      <= outst_d;
         abort_seen_q <= abort_seen_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         buf_q        <= buf_d;
         buf_full_q   <= buf_full_d;
         slot_q       <= slot_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign read_req        = issue;
   assign rd_adx          = next_adx_q;
   assign get_return_data = pop;
   assign sample_valid    = buf_full_q && !abort_seen_q;
   assign sample_out      = buf_q[SAMPLE_W*slot_q +: SAMPLE_W];

`ifdef READBACK_ADX_CHECK_EN
   logic [ADX_W-1:0] expect_adx_q, expect_adx_d;
   logic             adx_err_q, adx_err_d;

   always_comb begin
      expect_adx_d = expect_adx_q;
      adx_err_d    = adx_err_q;
      if (start_ok) begin
         expect_adx_d = base_adx;
         adx_err_d    = 1'b0;
      end else if (pop) begin
         if (rd_adx_return != expect_adx_q) adx_err_d = 1'b1;
         expect_adx_d = expect_adx_q + STEP;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         expect_adx_q <= '0;
         adx_err_q    <= 1'b0;
      end else begin
         expect_adx_q <= expect_adx_d;
         adx_err_q    <= adx_err_d;
      end
   end

   assign adx_error = adx_err_q;
`else
   // Return address is unused without the checker; the AND keeps it referenced yet folds to 0.
   assign adx_error = 1'b0 & (^rd_adx_return) & start_ok;
`endif

endmodule

// File: tb/tb_capture_readback_ctrl.sv
// Directed self-checking bench for capture_readback_ctrl with a small DRAM return model.
// Address-check expectations follow READBACK_ADX_CHECK_EN.
module tb_capture_readback_ctrl;

`ifdef READBACK_ADX_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [26:0]  base_adx = '0;
   logic [23:0]  word_count = '0;
   logic         busy, done, read_req, get_return_data;
   logic [26:0]  rd_adx;
   logic         read_allowed = 1'b1;
   logic         reads_pending, has_return_data;
   logic [127:0] rd_data_return;
   logic [26:0]  rd_adx_return;
   logic [31:0]  sample_out;
   logic         sample_valid;
   logic         sample_ready = 1'b1;
   logic         adx_error;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   capture_readback_ctrl #(
      .ADX_W(27), .DATA_W(128), .SAMPLE_W(32), .ADX_STEP(8), .MAX_OUTSTANDING(8), .CNT_W(24)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort),
      .base_adx(base_adx), .word_count(word_count), .busy(busy), .done(done),
      .read_req(read_req), .rd_adx(rd_adx), .read_allowed(read_allowed),
      .reads_pending(reads_pending), .has_return_data(has_return_data),
      .get_return_data(get_return_data), .rd_data_return(rd_data_return),
      .rd_adx_return(rd_adx_return), .sample_out(sample_out), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .adx_error(adx_error)
   );

   // DRAM model: each read returns 2 cycles after issue, in order.
   logic [26:0] da [0:255];
   logic [26:0] ra [0:255];
   int unsigned rt [0:255];
   int unsigned wr = 0, rd = 0, cyc = 0;
   int          npush = 0, bad_idx = -1;
   logic        hold = 1'b0, extra_pending = 1'b0, rand_mode = 1'b0;
   logic        cap_push = 1'b0, cap_pop = 1'b0;
   logic [26:0] cap_adx = '0;
   logic [7:0]  rdi;
   logic [26:0] ha;

   assign rdi             = rd[7:0];
   assign ha              = da[rdi];
   assign has_return_data = !hold && (wr != rd) && (rt[rdi] <= cyc);
   assign rd_data_return  = {3'b000, ha, 2'd3, 3'b000, ha, 2'd2, 3'b000, ha, 2'd1, 3'b000, ha, 2'd0};
   assign rd_adx_return   = ra[rdi];
   assign reads_pending   = (wr != rd) || extra_pending;

   always @(posedge clk) begin
      if (cap_push) begin
         da[wr[7:0]] = cap_adx;
         ra[wr[7:0]] = (npush == bad_idx) ? 27'h1FF : cap_adx;
         rt[wr[7:0]] = cyc + 2;
         wr++;
         npush++;
      end
      if (cap_pop) rd++;
      cyc++;
   end

   always @(posedge clk) begin
      #1;
      sample_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor on the falling edge, clear of input changes and DUT updates.
   int unsigned ngot = 0, nreq = 0, ndone = 0, npop = 0, nstall = 0, nhold_bad = 0;
   logic [31:0] got     [0:1023];
   logic [26:0] req_adx [0:1023];
   int unsigned req_cyc [0:1023];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_out = '0;

   always @(negedge clk) begin
      cap_push = read_req;
      cap_adx  = rd_adx;
      cap_pop  = get_return_data;
      if (read_req) begin
         req_adx[nreq[9:0]] = rd_adx;
         req_cyc[nreq[9:0]] = cyc;
         nreq++;
      end
      if (get_return_data) npop++;
      if (done) ndone++;
      if (prev_stall && (!sample_valid || (sample_out !== prev_out))) nhold_bad++;
      prev_stall = sample_valid && !sample_ready;
      prev_out   = sample_out;
      if (prev_stall) nstall++;
      if (sample_valid && sample_ready) begin
         got[ngot[9:0]] = sample_out;
         ngot++;
      end
   end

   function automatic logic [31:0] exp_sample(input logic [26:0] b, input int unsigned i);
      logic [26:0] a;
      a = b + 27'(8 * (i / 4));
      return {3'b000, a, 2'(i % 4)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [26:0] b, input logic [23:0] n);
      base_adx   = b;
      word_count = n;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int unsigned b_done, input int unsigned budget, output logic ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < budget; i++) begin
         tick();
         if (ndone > b_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({busy, done, read_req, get_return_data, sample_valid, adx_error} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b exp 000000",
                  {busy, done, read_req, get_return_data, sample_valid, adx_error});
      end
      vectors++;
      if ({rd_adx, sample_out} !== 59'b0) begin
         miscompares++;
         $display("FAIL reset_data: got rd_adx %h sample_out %h exp 0", rd_adx, sample_out);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic(input logic [26:0] b, input string nm);
      int unsigned b_req, b_got, b_done;
      logic        ok;
      logic [26:0] a1;
      b_req = nreq; b_got = ngot; b_done = ndone;
      a1 = b + 27'd8;
      pulse_start(b, 24'd2);
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy_hi: got %b exp 1", nm, busy); end
      wait_done(b_done, 200, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL %s_done_timeout: got 0 exp 1", nm); end
      repeat (3) tick();
      vectors++;
      if (ndone - b_done != 1) begin miscompares++; $display("FAIL %s_done_count: got %0d exp 1", nm, ndone - b_done); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_lo: got %b exp 0", nm, busy); end
      vectors++;
      if (nreq - b_req != 2) begin miscompares++; $display("FAIL %s_req_count: got %0d exp 2", nm, nreq - b_req); end
      vectors++;
      if (req_adx[b_req] !== b) begin miscompares++; $display("FAIL %s_adx0: got %h exp %h", nm, req_adx[b_req], b); end
      vectors++;
      if (req_adx[b_req+1] !== a1) begin miscompares++; $display("FAIL %s_adx1: got %h exp %h", nm, req_adx[b_req+1], a1); end
      vectors++;
      if (req_cyc[b_req+1] != req_cyc[b_req] + 1) begin
         miscompares++;
         $display("FAIL %s_req_consec: got gap %0d exp 1", nm, req_cyc[b_req+1] - req_cyc[b_req]);
      end
      vectors++;
      if (ngot - b_got != 8) begin miscompares++; $display("FAIL %s_sample_count: got %0d exp 8", nm, ngot - b_got); end
      for (int unsigned i = 0; i < 8; i++) begin
         vectors++;
         if (got[b_got+i] !== exp_sample(b, i)) begin
            miscompares++;
            $display("FAIL %s_sample[%0d]: got %h exp %h", nm, i, got[b_got+i], exp_sample(b, i));
         end
      end
   endtask

   task automatic test_zero_and_ignore();
      int unsigned b_req, b_got, b_done;
      logic        ok;
      b_req = nreq; b_done = ndone;
      pulse_start(27'h500, 24'd0);
      vectors++;
      if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL zero_cycle1: got busy,done %b exp 10", {busy, done}); end
      tick();
      vectors++;
      if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL zero_cycle2: got busy,done %b exp 01", {busy, done}); end
      tick();
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_pulse: got %b exp 0", done); end
      vectors++;
      if (nreq != b_req) begin miscompares++; $display("FAIL zero_no_req: got %0d exp 0", nreq - b_req); end

      b_req = nreq; b_got = ngot; b_done = ndone;
      pulse_start(27'h200, 24'd3);
      tick();
      base_adx = 27'h300; word_count = 24'd5; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(b_done, 300, ok);
      repeat (3) tick();
      vectors++;
      if (!ok || (ndone - b_done != 1)) begin miscompares++; $display("FAIL ignore_done: got %0d exp 1", ndone - b_done); end
      vectors++;
      if (nreq - b_req != 3) begin miscompares++; $display("FAIL ignore_req_count: got %0d exp 3", nreq - b_req); end
      vectors++;
      if (req_adx[b_req+2] !== 27'h210) begin miscompares++; $display("FAIL ignore_adx2: got %h exp 210", req_adx[b_req+2]); end
      vectors++;
      if (ngot - b_got != 12) begin miscompares++; $display("FAIL ignore_samples: got %0d exp 12", ngot - b_got); end
   endtask

   task automatic test_outstanding();
      int unsigned b_req, b_got, b_done;
      logic        ok;
      b_req = nreq; b_got = ngot; b_done = ndone;
      hold = 1'b1;
      pulse_start(27'h1000, 24'd20);
      repeat (30) tick();
      vectors++;
      if (nreq - b_req != 8) begin miscompares++; $display("FAIL outst_stall_count: got %0d exp 8", nreq - b_req); end
      vectors++;
      if (read_req !== 1'b0) begin miscompares++; $display("FAIL outst_stall_req: got %b exp 0", read_req); end
      hold = 1'b0;
      wait_done(b_done, 1000, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL outst_done_timeout: got 0 exp 1"); end
      vectors++;
      if (nreq - b_req != 20) begin miscompares++; $display("FAIL outst_req_total: got %0d exp 20", nreq - b_req); end
      vectors++;
      if (req_adx[b_req+19] !== 27'h1098) begin miscompares++; $display("FAIL outst_last_adx: got %h exp 1098", req_adx[b_req+19]); end
      vectors++;
      if (ngot - b_got != 80) begin miscompares++; $display("FAIL outst_sample_count: got %0d exp 80", ngot - b_got); end
      for (int unsigned i = 0; i < 80; i++) begin
         vectors++;
         if (got[b_got+i] !== exp_sample(27'h1000, i)) begin
            miscompares++;
            $display("FAIL outst_sample[%0d]: got %h exp %h", i, got[b_got+i], exp_sample(27'h1000, i));
         end
      end
   endtask

   task automatic test_backpressure();
      int unsigned b_got, b_done, b_stall, b_bad;
      logic        ok;
      b_got = ngot; b_done = ndone; b_stall = nstall; b_bad = nhold_bad;
      rand_mode = 1'b1;
      pulse_start(27'h2000, 24'd6);
      wait_done(b_done, 1000, ok);
      rand_mode = 1'b0;
      tick();
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_done_timeout: got 0 exp 1"); end
      vectors++;
      if (ngot - b_got != 24) begin miscompares++; $display("FAIL bp_sample_count: got %0d exp 24", ngot - b_got); end
      vectors++;
      if (nstall == b_stall) begin miscompares++; $display("FAIL bp_stalls_seen: got 0 exp >0"); end
      vectors++;
      if (nhold_bad != b_bad) begin miscompares++; $display("FAIL bp_hold_stable: got %0d changes exp 0", nhold_bad - b_bad); end
      for (int unsigned i = 0; i < 24; i++) begin
         vectors++;
         if (got[b_got+i] !== exp_sample(27'h2000, i)) begin
            miscompares++;
            $display("FAIL bp_sample[%0d]: got %h exp %h", i, got[b_got+i], exp_sample(27'h2000, i));
         end
      end
   endtask

   task automatic test_abort();
      int unsigned b_req, b_got, b_done, b_pop;
      logic        ok;
      b_req = nreq; b_got = ngot; b_done = ndone; b_pop = npop;
      extra_pending = 1'b1;
      pulse_start(27'h3000, 24'd10);
      for (int unsigned i = 0; i < 50; i++) begin
         tick();
         if (nreq - b_req == 4) begin
            abort = 1'b1;
            break;
         end
      end
      vectors++;
      if (abort !== 1'b1) begin miscompares++; $display("FAIL abort_reach4: got %0d reqs exp 4", nreq - b_req); end
      repeat (30) tick();
      vectors++;
      if (nreq - b_req != 4) begin miscompares++; $display("FAIL abort_req_count: got %0d exp 4", nreq - b_req); end
      vectors++;
      if (npop - b_pop != 4) begin miscompares++; $display("FAIL abort_pops: got %0d exp 4", npop - b_pop); end
      vectors++;
      if (ngot - b_got != 2) begin miscompares++; $display("FAIL abort_samples: got %0d exp 2", ngot - b_got); end
      vectors++;
      if (got[b_got+1] !== exp_sample(27'h3000, 1)) begin
         miscompares++;
         $display("FAIL abort_sample1: got %h exp %h", got[b_got+1], exp_sample(27'h3000, 1));
      end
      vectors++;
      if ({busy, ndone - b_done} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL abort_wait_pending: got busy %b dones %0d exp 1 0", busy, ndone - b_done);
      end
      extra_pending = 1'b0;
      wait_done(b_done, 100, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL abort_done_timeout: got 0 exp 1"); end
      abort = 1'b0;
      tick();
   endtask

   task automatic test_adx_check();
      int unsigned b_got, b_done, b_pop;
      logic        ok, c1, c2;
      b_got = ngot; b_done = ndone; b_pop = npop;
      c1 = 1'b0; c2 = 1'b0;
      bad_idx = npush + 1;
      pulse_start(27'h400, 24'd3);
      for (int unsigned i = 0; i < 200 && ndone == b_done; i++) begin
         tick();
         if (!c1 && (npop - b_pop == 1)) begin
            c1 = 1'b1;
            vectors++;
            if (adx_error !== 1'b0) begin miscompares++; $display("FAIL adx_after_pop1: got %b exp 0", adx_error); end
         end
         if (!c2 && (npop - b_pop == 2)) begin
            c2 = 1'b1;
            vectors++;
            if (adx_error !== EXP_ERR) begin miscompares++; $display("FAIL adx_after_pop2: got %b exp %b", adx_error, EXP_ERR); end
         end
      end
      vectors++;
      if (!(c1 && c2) || ndone == b_done) begin miscompares++; $display("FAIL adx_progress: got pops %0d exp 3 and done", npop - b_pop); end
      tick();
      vectors++;
      if (adx_error !== EXP_ERR) begin miscompares++; $display("FAIL adx_sticky: got %b exp %b", adx_error, EXP_ERR); end
      vectors++;
      if (got[b_got+5] !== exp_sample(27'h400, 5)) begin
         miscompares++;
         $display("FAIL adx_data_pass: got %h exp %h", got[b_got+5], exp_sample(27'h400, 5));
      end
      bad_idx = -1;
      b_done = ndone;
      pulse_start(27'h600, 24'd0);
      vectors++;
      if (adx_error !== 1'b0) begin miscompares++; $display("FAIL adx_cleared: got %b exp 0", adx_error); end
      wait_done(b_done, 20, ok);
      tick();
   endtask

   task automatic test_reset_mid();
      logic bad;
      bad = 1'b0;
      hold = 1'b1;
      pulse_start(27'h700, 24'd5);
      repeat (4) tick();
      resetn = 1'b0;
      #1;
      vectors++;
      if ({busy, done, read_req, get_return_data, sample_valid, adx_error, rd_adx} !== 33'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got busy %b req %b rd_adx %h exp 0", busy, read_req, rd_adx);
      end
      tick();
      hold = 1'b0;
      resetn = 1'b1;
      for (int unsigned i = 0; i < 6; i++) begin
         tick();
         if (get_return_data !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad) begin miscompares++; $display("FAIL midreset_late_return: got pop/busy 1 exp 0"); end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic(27'h100, "basic");
      test_basic(27'h7FFFFF8, "wrap");
      test_zero_and_ignore();
      test_outstanding();
      test_backpressure();
      test_abort();
      test_adx_check();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
